reg_file_mp: RTL

- Parametrised multi-port general-purpose register file for the dual-issue integer core.
- Successor to the single-write/two-read register file. Adds:
  - a configurable number of read ports;
  - two write ports with ordered priority;
  - write-to-read bypass per port;
  - an integrated per-register busy scoreboard that issue logic uses for RAW hazard detection.
- Sits between decode/issue (reads, allocations) and writeback (writes).

---
 rtl/reg_file_mp.sv | 102 ++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port register file, two prioritised write ports, per-port
//            write-to-read bypass and an integrated busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 w_en,
    input  logic [2*ADDR_W-1:0]        w_addr,
    input  logic [2*DATA_W-1:0]        w_data,
    input  logic [NUM_RD-1:0]          r_en,
    input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
    output logic [NUM_RD*DATA_W-1:0]   r_data,
    output logic [NUM_RD-1:0]          r_busy,
    input  logic [1:0]                 alloc_en,
    input  logic [2*ADDR_W-1:0]        alloc_addr,
    input  logic                       flush
);

    localparam int c_DEPTH = 2**ADDR_W;

    logic [c_DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [c_DEPTH-1:0]             busy_q, busy_d;

    // Later assignments override earlier ones: port 1 beats port 0, an
    // allocation beats a write clear, and flush beats everything.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < 2; k++) begin
            if (w_en[k]) begin
                regs_d[w_addr[k*ADDR_W +: ADDR_W]] = w_data[k*DATA_W +: DATA_W];
                busy_d[w_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (alloc_en[k]) begin
                busy_d[alloc_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit1;
        logic              w_hit0;
        logic              w_zero;
        logic [DATA_W-1:0] w_rdata;
        logic              w_rbusy;

        assign w_ra   = r_addr[i*ADDR_W +: ADDR_W];
        assign w_hit1 = w_en[1] && (w_addr[ADDR_W +: ADDR_W] == w_ra);
        assign w_hit0 = w_en[0] && (w_addr[0 +: ADDR_W] == w_ra);
        assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

        // Reset also masks the bypass path so nothing leaks out while rst=1.
        always_comb begin
            w_rdata = '0;
            w_rbusy = 1'b0;
            if (!rst && r_en[i] && !w_zero) begin
                if (w_hit1) begin
                    w_rdata = w_data[DATA_W +: DATA_W];
                end else if (w_hit0) begin
                    w_rdata = w_data[0 +: DATA_W];
                end else begin
                    w_rdata = regs_q[w_ra];
                    w_rbusy = busy_q[w_ra];
                end
            end
        end

        assign r_data[i*DATA_W +: DATA_W] = w_rdata;
        assign r_busy[i]                  = w_rbusy;
    end

endmodule
`default_nettype wire
